// File: rtl/bcd_count_chain.sv
// Multi-digit BCD counter: trigger-selected digits increment on inc_clk,
// carries ripple one digit per clock, ref_clk snapshots the live count.
module bcd_count_chain #(
    parameter int DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DIGITS-1:0]     trigger,
    input  logic                  inc_clk,
    input  logic                  ref_clk,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   count_out,
    output logic                  busy,
    output logic                  overflow
);

    typedef enum logic {
        IDLE,
        RIPPLE
    } state_t;

    state_t state, state_nx;

    logic [DIGITS-1:0][3:0] live, live_nx;
    logic [DIGITS-1:0]      pend, pend_nx;
    logic [DIGITS-1:0]      carry;
    logic                   overflow_nx;

    assign busy = (state == RIPPLE);

    always_comb begin
        state_nx    = state;
        live_nx     = live;
        pend_nx     = pend;
        overflow_nx = overflow;
        carry       = '0;
        if (clear) begin
            state_nx    = IDLE;
            live_nx     = '0;
            pend_nx     = '0;
            overflow_nx = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (inc_clk) begin
                        pend_nx = trigger;
                        if (trigger != '0) state_nx = RIPPLE;
                    end
                end
                RIPPLE: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (pend[i]) begin
                            if (live[i] == 4'd9) begin
                                live_nx[i] = 4'd0;
                                carry[i]   = 1'b1;
                            end else begin
                                live_nx[i] = live[i] + 4'd1;
                            end
                        end
                    end
                    // carry out of the top digit falls off the shift
                    pend_nx = carry << 1;
                    if (carry[DIGITS-1]) overflow_nx = 1'b1;
                    if (pend_nx == '0) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            live      <= '0;
            pend      <= '0;
            overflow  <= 1'b0;
            count_out <= '0;
        end else begin
            state    <= state_nx;
            live     <= live_nx;
            pend     <= pend_nx;
            overflow <= overflow_nx;
            // snapshot uses the pre-clear / pre-increment value
            if (ref_clk) count_out <= live;
        end
    end

endmodule

// File: tb/tb_bcd_count_chain.sv
// Directed bench for bcd_count_chain with a decimal reference model
// and a scoreboard queue for the count_out snapshots.
module tb_bcd_count_chain;

    localparam int D = 6;

    logic           clk;
    logic           reset;
    logic [D-1:0]   trigger;
    logic           inc_clk;
    logic           ref_clk;
    logic           clear;
    logic [4*D-1:0] count_out;
    logic           busy;
    logic           overflow;

    int errors = 0;
    int checks = 0;

    longint     model;
    logic       movf;
    logic [4*D-1:0] sb[$];

    bcd_count_chain #(.DIGITS(D)) dut (
        .clk(clk),
        .reset(reset),
        .trigger(trigger),
        .inc_clk(inc_clk),
        .ref_clk(ref_clk),
        .clear(clear),
        .count_out(count_out),
        .busy(busy),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    function automatic logic [4*D-1:0] to_bcd(input longint v);
        logic [4*D-1:0] r;
        longint p;
        r = '0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic add_model(input logic [D-1:0] trig);
        longint p;
        p = 1;
        for (int i = 0; i < D; i++) begin
            if (trig[i]) model = model + p;
            p = p * 10;
        end
        if (model >= p) begin
            model = model - p;
            movf  = 1'b1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [4*D-1:0] e;
        e = sb.pop_front();
        chk(tag, 64'(count_out), 64'(e));
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < D; i++) begin
                if (count_out[4*i +: 4] > 4'd9) begin
                    errors++;
                    $error("FAIL non_bcd: observed=%0h expected=digit<=9",
                           count_out);
                end
            end
        end
    end

    task automatic wait_idle(input string tag, input int exp_busy);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_done"}, 64'(n < 40), 64'd1);
        if (exp_busy >= 0) chk({tag, "_busy"}, 64'(n), 64'(exp_busy));
        chk({tag, "_ovf"}, 64'(overflow), 64'(movf));
    endtask

    task automatic inc(input string tag, input logic [D-1:0] trig,
                       input int exp_busy, input bit with_ref);
        @(negedge clk);
        trigger = trig;
        inc_clk = 1'b1;
        ref_clk = with_ref;
        if (with_ref) sb.push_back(to_bcd(model));
        add_model(trig);
        @(negedge clk);
        inc_clk = 1'b0;
        ref_clk = 1'b0;
        trigger = '0;
        if (with_ref) sb_check({tag, "_ref"});
        wait_idle(tag, exp_busy);
    endtask

    task automatic preload(input logic [D-1:0] trig, input int times);
        repeat (times) inc("pre", trig, -1, 1'b0);
    endtask

    task automatic do_ref(input string tag);
        @(negedge clk);
        ref_clk = 1'b1;
        sb.push_back(to_bcd(model));
        @(negedge clk);
        ref_clk = 1'b0;
        sb_check(tag);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model = 0;
        movf  = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        trigger = '0;
        inc_clk = 1'b0;
        ref_clk = 1'b0;
        clear   = 1'b0;
        model   = 0;
        movf    = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_count", 64'(count_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);

        // single increment, no carry
        inc("t1", 6'b000001, 1, 1'b0);
        do_ref("t1_ref");

        // ref and inc together: snapshot is pre-increment
        inc("inc_ref", 6'b000001, 1, 1'b1);
        do_ref("inc_ref_after");

        // ref and clear together: snapshot is pre-clear
        @(negedge clk);
        ref_clk = 1'b1;
        clear   = 1'b1;
        sb.push_back(to_bcd(model));
        @(negedge clk);
        ref_clk = 1'b0;
        clear   = 1'b0;
        model   = 0;
        movf    = 1'b0;
        sb_check("ref_clear");
        @(negedge clk);
        chk("clear_hold", 64'(count_out), 64'h000002);

        // 99 + 1: carries through two digits
        preload(6'b000011, 9);
        inc("t2", 6'b000001, 3, 1'b0);
        do_ref("t2_ref");

        // 999999 + 1: full ripple and overflow
        do_clear();
        preload(6'b111111, 9);
        do_ref("t3_pre");
        inc("t3", 6'b000001, 6, 1'b0);
        chk("t3_ovf_set", 64'(overflow), 64'd1);
        do_ref("t3_ref");

        // inc_clk during busy is ignored
        preload(6'b000111, 9);
        @(negedge clk);
        trigger = 6'b000001;
        inc_clk = 1'b1;
        add_model(6'b000001);
        @(negedge clk);
        chk("t5_busy_on", 64'(busy), 64'd1);
        trigger = 6'b100000;
        @(negedge clk);
        inc_clk = 1'b0;
        trigger = '0;
        wait_idle("t5_ign", -1);
        do_ref("t5_ign_ref");

        // clear mid-ripple, overflow still set from before
        chk("t5_ovf_pre", 64'(overflow), 64'd1);
        preload(6'b000111, 9);
        @(negedge clk);
        trigger = 6'b000001;
        inc_clk = 1'b1;
        @(negedge clk);
        inc_clk = 1'b0;
        trigger = '0;
        @(negedge clk);
        chk("t5_mid", 64'(busy), 64'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model = 0;
        movf  = 1'b0;
        chk("t5_clr_busy", 64'(busy), 64'd0);
        chk("t5_clr_ovf", 64'(overflow), 64'd0);
        chk("t5_clr_hold", 64'(count_out), 64'h001000);
        do_ref("t5_clr_ref");

        // 9 + 11: carry merges into digit 1
        preload(6'b000001, 9);
        inc("t4", 6'b000011, 2, 1'b0);
        do_ref("t4_ref");

        // async reset mid-ripple
        do_clear();
        for (int i = 0; i < D; i++) preload(6'(1 << i), D - i);
        do_ref("t6_pre");
        preload(6'b000001, 3);
        @(negedge clk);
        trigger = 6'b000001;
        inc_clk = 1'b1;
        @(negedge clk);
        inc_clk = 1'b0;
        trigger = '0;
        chk("t6_mid", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        chk("t6_count", 64'(count_out), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_ovf", 64'(overflow), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model = 0;
        movf  = 1'b0;
        do_ref("t6_ref");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
